// File: rtl/xge_tx_arbiter.sv
// xge_tx_arbiter: round-robin packet arbiter feeding the xge_mac POS-L3 TX port.
// One requester is granted per packet (SOP..EOP). Accepted beats are forwarded
// through a single register stage onto pkt_tx_*. All requesters are throttled
// while pkt_tx_full is high.
//
// Ports:
//   clk_156m25, reset_156m25_n        clock, async active-low reset
//   req_val/sop/eop [NUM_REQ]         per-requester beat qualifiers
//   req_data [64*NUM_REQ]             packed beat data, requester i at [64*i+:64]
//   req_mod  [3*NUM_REQ]              packed valid-byte modulo, requester i at [3*i+:3]
//   req_rdy  [NUM_REQ]                combinational accept (beat taken on val & rdy)
//   pkt_tx_full                       MAC TX FIFO almost-full
//   pkt_tx_val/sop/eop/data/mod       registered beat to MAC
//   grant_id [3]                      current or last grantee
//   proto_err                         1-cycle pulse on grantee protocol error
//
// Optional feature: define XGE_TX_ARB_WDOG_EN to build the idle-beat watchdog
// that terminates a stalled packet after WDOG_CYCLES idle cycles.
module xge_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                   clk_156m25,
  input  logic                   reset_156m25_n,
  input  logic [NUM_REQ-1:0]     req_val,
  input  logic [NUM_REQ-1:0]     req_sop,
  input  logic [NUM_REQ-1:0]     req_eop,
  input  logic [64*NUM_REQ-1:0]  req_data,
  input  logic [3*NUM_REQ-1:0]   req_mod,
  output logic [NUM_REQ-1:0]     req_rdy,
  input  logic                   pkt_tx_full,
  output logic                   pkt_tx_val,
  output logic                   pkt_tx_sop,
  output logic                   pkt_tx_eop,
  output logic [63:0]            pkt_tx_data,
  output logic [2:0]             pkt_tx_mod,
  output logic [2:0]             grant_id,
  output logic                   proto_err
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned MOD_W  = 3;
  localparam int unsigned ID_W   = 3;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_chk
    $error("xge_tx_arbiter: NUM_REQ must be 2..8");
  end
  if (WDOG_CYCLES < 1) begin : g_wdog_chk
    $error("xge_tx_arbiter: WDOG_CYCLES must be at least 1");
  end

  typedef enum logic {ST_IDLE, ST_XFER} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                first_q, first_d;
  logic                pkt_tx_val_q, pkt_tx_val_d;
  logic                pkt_tx_sop_q, pkt_tx_sop_d;
  logic                pkt_tx_eop_q, pkt_tx_eop_d;
  logic [DATA_W-1:0]   pkt_tx_data_q, pkt_tx_data_d;
  logic [MOD_W-1:0]    pkt_tx_mod_q, pkt_tx_mod_d;
  logic                proto_err_q, proto_err_d;

  logic                win_found_c;
  logic [ID_W-1:0]     win_id_c;
  logic [ID_W:0]       cand_c;
  logic                sel_val_c, sel_sop_c, sel_eop_c;
  logic [DATA_W-1:0]   sel_data_c;
  logic [MOD_W-1:0]    sel_mod_c;
  logic                accept_c;
  logic                wdog_fire_c;
  logic [ID_W-1:0]     next_ptr_c;

  // Round-robin winner: first index with val & sop, starting at rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    win_found_c = 1'b0;
    win_id_c    = '0;
    cand_c      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_c = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand_c >= (ID_W+1)'(NUM_REQ)) cand_c = cand_c - (ID_W+1)'(NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found_c && cand_c == (ID_W+1)'(i) && req_val[i] && req_sop[i]) begin
          win_found_c = 1'b1;
          win_id_c    = ID_W'(i);
        end
      end
    end
  end

  // Grantee beat mux.
  always_comb begin
    sel_val_c  = 1'b0;
    sel_sop_c  = 1'b0;
    sel_eop_c  = 1'b0;
    sel_data_c = '0;
    sel_mod_c  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        sel_val_c  = req_val[i];
        sel_sop_c  = req_sop[i];
        sel_eop_c  = req_eop[i];
        sel_data_c = req_data[DATA_W*i +: DATA_W];
        sel_mod_c  = req_mod[MOD_W*i +: MOD_W];
      end
    end
  end

  assign accept_c   = (state_q == ST_XFER) && sel_val_c && !pkt_tx_full && !wdog_fire_c;
  assign next_ptr_c = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

  // Only the grantee sees ready; suppressed while the watchdog terminates the packet.
  always_comb begin
    req_rdy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rdy[i] = (state_q == ST_XFER) && !pkt_tx_full && !wdog_fire_c
                   && (grant_id_q == ID_W'(i));
    end
  end

`ifdef XGE_TX_ARB_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;

  assign wdog_fire_c = (state_q == ST_XFER) && (wdog_cnt_q == WDOG_W'(WDOG_CYCLES));

  // Counts grantee idle cycles that are not excused by back-pressure.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (state_q != ST_XFER || accept_c || wdog_fire_c) wdog_cnt_d = '0;
    else if (!sel_val_c && !pkt_tx_full)               wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) wdog_cnt_q <= '0;
    else                 wdog_cnt_q <= wdog_cnt_d;
  end
`else
  assign wdog_fire_c = 1'b0;
`endif

  // Next-state and registered beat outputs.
  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    first_d       = first_q;
    pkt_tx_val_d  = 1'b0;
    pkt_tx_sop_d  = 1'b0;
    pkt_tx_eop_d  = 1'b0;
    pkt_tx_mod_d  = '0;
    pkt_tx_data_d = pkt_tx_data_q;
    proto_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found_c) begin
          grant_id_d = win_id_c;
          first_d    = 1'b1;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (wdog_fire_c) begin
          pkt_tx_val_d  = 1'b1;
          pkt_tx_eop_d  = 1'b1;
          pkt_tx_data_d = '0;
          proto_err_d   = 1'b1;
          state_d       = ST_IDLE;
          rr_ptr_d      = next_ptr_c;
        end else if (accept_c) begin
          pkt_tx_val_d  = 1'b1;
          pkt_tx_sop_d  = sel_sop_c;
          pkt_tx_eop_d  = sel_eop_c;
          pkt_tx_mod_d  = sel_mod_c;
          pkt_tx_data_d = sel_data_c;
          first_d       = 1'b0;
          // SOP on any beat but the first is forwarded but flagged.
          proto_err_d   = sel_sop_c && !first_q;
          if (sel_eop_c) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr_c;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state_q       <= ST_IDLE;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      first_q       <= 1'b0;
      pkt_tx_val_q  <= 1'b0;
      pkt_tx_sop_q  <= 1'b0;
      pkt_tx_eop_q  <= 1'b0;
      pkt_tx_data_q <= '0;
      pkt_tx_mod_q  <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      first_q       <= first_d;
      pkt_tx_val_q  <= pkt_tx_val_d;
      pkt_tx_sop_q  <= pkt_tx_sop_d;
      pkt_tx_eop_q  <= pkt_tx_eop_d;
      pkt_tx_data_q <= pkt_tx_data_d;
      pkt_tx_mod_q  <= pkt_tx_mod_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign pkt_tx_val  = pkt_tx_val_q;
  assign pkt_tx_sop  = pkt_tx_sop_q;
  assign pkt_tx_eop  = pkt_tx_eop_q;
  assign pkt_tx_data = pkt_tx_data_q;
  assign pkt_tx_mod  = pkt_tx_mod_q;
  assign grant_id    = grant_id_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_xge_tx_arbiter.sv
// Directed bench for xge_tx_arbiter (NUM_REQ=4): table vectors per cycle plus
// hand sequences for round-robin order, reset mid-packet and the watchdog.
module tb_xge_tx_arbiter;

  localparam int unsigned N = 4;
`ifdef XGE_TX_ARB_WDOG_EN
  localparam int unsigned WD = 8;
`else
  localparam int unsigned WD = 64;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_val = '0, req_sop = '0, req_eop = '0;
  logic [64*N-1:0]   req_data = '0;
  logic [3*N-1:0]    req_mod = '0;
  logic [N-1:0]      req_rdy;
  logic              pkt_tx_full = 1'b0;
  logic              pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
  logic [63:0]       pkt_tx_data;
  logic [2:0]        pkt_tx_mod, grant_id;
  logic              proto_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xge_tx_arbiter #(.NUM_REQ(N), .WDOG_CYCLES(WD)) dut (
    .clk_156m25(clk), .reset_156m25_n(rst_n),
    .req_val(req_val), .req_sop(req_sop), .req_eop(req_eop),
    .req_data(req_data), .req_mod(req_mod), .req_rdy(req_rdy),
    .pkt_tx_full(pkt_tx_full),
    .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop), .pkt_tx_eop(pkt_tx_eop),
    .pkt_tx_data(pkt_tx_data), .pkt_tx_mod(pkt_tx_mod),
    .grant_id(grant_id), .proto_err(proto_err)
  );

  typedef struct {
    string       name;
    bit          rst;
    logic [3:0]  val, sop, eop;
    logic        full;
    logic [63:0] d;
    logic [2:0]  m;
    logic [3:0]  e_rdy;
    logic        e_val, e_sop, e_eop;
    logic [63:0] e_data;
    logic [2:0]  e_mod, e_gid;
    logic        e_perr;
  } vec_t;

  vec_t vecs[$];

  // Lane i carries d with the requester index in bits [55:48].
  function automatic logic [63:0] lane(input logic [63:0] d, input int i);
    return d | (64'(i) << 48);
  endfunction

  task automatic drive(input logic [3:0] val, input logic [3:0] sop, input logic [3:0] eop,
                       input logic full, input logic [63:0] d, input logic [2:0] m);
    req_val = val; req_sop = sop; req_eop = eop; pkt_tx_full = full;
    for (int i = 0; i < N; i++) begin
      req_data[64*i +: 64] = lane(d, i);
      req_mod[3*i +: 3]    = m;
    end
  endtask

  task automatic check(input string name, input logic [3:0] e_rdy, input logic e_val,
                       input logic e_sop, input logic e_eop, input logic [63:0] e_data,
                       input logic [2:0] e_mod, input logic [2:0] e_gid, input logic e_perr);
    logic [77:0] act, exp;
    act = {req_rdy, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_data, pkt_tx_mod, grant_id, proto_err};
    exp = {e_rdy, e_val, e_sop, e_eop, e_data, e_mod, e_gid, e_perr};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got rdy=%b val=%b sop=%b eop=%b data=%h mod=%0d gid=%0d perr=%b want rdy=%b val=%b sop=%b eop=%b data=%h mod=%0d gid=%0d perr=%b",
               name, req_rdy, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_data, pkt_tx_mod, grant_id, proto_err,
               e_rdy, e_val, e_sop, e_eop, e_data, e_mod, e_gid, e_perr);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(4'b0, 4'b0, 4'b0, 1'b0, 64'h0, 3'd0);
    #1 check("reset", 4'b0, 0, 0, 0, 64'h0, 3'd0, 3'd0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(input string name, input bit rst, input logic [3:0] val, input logic [3:0] sop,
                     input logic [3:0] eop, input logic full, input logic [63:0] d, input logic [2:0] m,
                     input logic [3:0] e_rdy, input logic e_val, input logic e_sop, input logic e_eop,
                     input logic [63:0] e_data, input logic [2:0] e_mod, input logic [2:0] e_gid,
                     input logic e_perr);
    vec_t v;
    v.name = name; v.rst = rst; v.val = val; v.sop = sop; v.eop = eop; v.full = full;
    v.d = d; v.m = m; v.e_rdy = e_rdy; v.e_val = e_val; v.e_sop = e_sop; v.e_eop = e_eop;
    v.e_data = e_data; v.e_mod = e_mod; v.e_gid = e_gid; v.e_perr = e_perr;
    vecs.push_back(v);
  endtask

  initial begin
    // T1: req0 3-beat packet, mod 5 on EOP.
    add("t1_idle",  1, 4'b0001, 4'b0001, 4'b0000, 0, 64'h11, 0, 4'b0000, 0,0,0, 64'h0,  0, 0, 0);
    add("t1_grant", 0, 4'b0001, 4'b0001, 4'b0000, 0, 64'h11, 0, 4'b0001, 0,0,0, 64'h0,  0, 0, 0);
    add("t1_b1",    0, 4'b0001, 4'b0000, 4'b0000, 0, 64'h22, 0, 4'b0001, 1,1,0, 64'h11, 0, 0, 0);
    add("t1_b2",    0, 4'b0001, 4'b0000, 4'b0001, 0, 64'h33, 5, 4'b0001, 1,0,0, 64'h22, 0, 0, 0);
    add("t1_b3",    0, 4'b0000, 4'b0000, 4'b0000, 0, 64'h0,  0, 4'b0000, 1,0,1, 64'h33, 5, 0, 0);
    add("t1_gap",   0, 4'b0000, 4'b0000, 4'b0000, 0, 64'h0,  0, 4'b0000, 0,0,0, 64'h33, 0, 0, 0);
    // T4: req0 valid without SOP is ineligible; req1 wins, SOP on 2nd beat flags proto_err.
    add("t4_idle",  1, 4'b0011, 4'b0010, 4'b0000, 0, 64'h44, 0, 4'b0000, 0,0,0, 64'h0, 0, 0, 0);
    add("t4_grant", 0, 4'b0011, 4'b0010, 4'b0000, 0, 64'h44, 0, 4'b0010, 0,0,0, 64'h0, 0, 1, 0);
    add("t4_b1",    0, 4'b0011, 4'b0010, 4'b0010, 0, 64'h55, 2, 4'b0010, 1,1,0, 64'h0001_0000_0000_0044, 0, 1, 0);
    add("t4_b2",    0, 4'b0001, 4'b0000, 4'b0000, 0, 64'h0,  0, 4'b0000, 1,1,1, 64'h0001_0000_0000_0055, 2, 1, 1);
    add("t4_after", 0, 4'b0001, 4'b0000, 4'b0000, 0, 64'h0,  0, 4'b0000, 0,0,0, 64'h0001_0000_0000_0055, 0, 1, 0);
    // T3: req2 mid-packet, full for 10 cycles while EOP is offered.
    add("t3_idle",  1, 4'b0100, 4'b0100, 4'b0000, 0, 64'h61, 0, 4'b0000, 0,0,0, 64'h0, 0, 0, 0);
    add("t3_grant", 0, 4'b0100, 4'b0100, 4'b0000, 0, 64'h61, 0, 4'b0100, 0,0,0, 64'h0, 0, 2, 0);
    add("t3_b1",    0, 4'b0100, 4'b0000, 4'b0000, 0, 64'h62, 0, 4'b0100, 1,1,0, 64'h0002_0000_0000_0061, 0, 2, 0);
    add("t3_full0", 0, 4'b0100, 4'b0000, 4'b0100, 1, 64'h63, 7, 4'b0000, 1,0,0, 64'h0002_0000_0000_0062, 0, 2, 0);
    for (int k = 1; k < 10; k++)
      add($sformatf("t3_full%0d", k), 0, 4'b0100, 4'b0000, 4'b0100, 1, 64'h63, 7,
          4'b0000, 0,0,0, 64'h0002_0000_0000_0062, 0, 2, 0);
    add("t3_resume",0, 4'b0100, 4'b0000, 4'b0100, 0, 64'h63, 7, 4'b0100, 0,0,0, 64'h0002_0000_0000_0062, 0, 2, 0);
    add("t3_eop",   0, 4'b0000, 4'b0000, 4'b0000, 0, 64'h0,  0, 4'b0000, 1,0,1, 64'h0002_0000_0000_0063, 7, 2, 0);
    add("t3_gap",   0, 4'b0000, 4'b0000, 4'b0000, 0, 64'h0,  0, 4'b0000, 0,0,0, 64'h0002_0000_0000_0063, 0, 2, 0);

    foreach (vecs[n]) begin
      if (vecs[n].rst) do_reset();
      @(negedge clk);
      drive(vecs[n].val, vecs[n].sop, vecs[n].eop, vecs[n].full, vecs[n].d, vecs[n].m);
      #1 check(vecs[n].name, vecs[n].e_rdy, vecs[n].e_val, vecs[n].e_sop, vecs[n].e_eop,
               vecs[n].e_data, vecs[n].e_mod, vecs[n].e_gid, vecs[n].e_perr);
    end

    // T2: all four hold 1-beat packets from reset; order 0,1,2,3,0 with one idle cycle.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      drive(4'b1111, 4'b1111, 4'b1111, 0, 64'hA0, 3'd1);
      #1;
      if (c < 2)
        check($sformatf("t2_c%0d", c), (c == 1) ? 4'b0001 : 4'b0000, 0,0,0, 64'h0, 0, 0, 0);
      else if (c % 2 == 0)
        check($sformatf("t2_c%0d", c), 4'b0000, 1,1,1, lane(64'hA0, ((c-2)/2) % 4), 3'd1,
              3'(((c-2)/2) % 4), 0);
      else
        check($sformatf("t2_c%0d", c), 4'(1 << (((c-1)/2) % 4)), 0,0,0,
              lane(64'hA0, ((c-3)/2) % 4), 0, 3'(((c-1)/2) % 4), 0);
    end

    // T5: reset mid-packet from req1, then req3 is granted first.
    do_reset();
    @(negedge clk); drive(4'b0010, 4'b0010, 4'b0000, 0, 64'h81, 0);
    @(negedge clk); drive(4'b0010, 4'b0010, 4'b0000, 0, 64'h81, 0);
    @(negedge clk); drive(4'b0010, 4'b0000, 4'b0000, 0, 64'h82, 0);
    #1 check("t5_mid", 4'b0010, 1,1,0, 64'h0001_0000_0000_0081, 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(4'b1000, 4'b1000, 4'b1000, 0, 64'h77, 3);
    #1 check("t5_rst", 4'b0000, 0,0,0, 64'h0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    #1 check("t5_grant3", 4'b1000, 0,0,0, 64'h0, 0, 3, 0);
    @(negedge clk); drive(4'b0000, 4'b0000, 4'b0000, 0, 64'h0, 0);
    #1 check("t5_beat", 4'b0000, 1,1,1, 64'h0003_0000_0000_0077, 3, 3, 0);

`ifdef XGE_TX_ARB_WDOG_EN
    // T6: req0 stalls after its first beat; watchdog terminates, req1 follows.
    do_reset();
    @(negedge clk); drive(4'b0011, 4'b0011, 4'b0010, 0, 64'h91, 0);
    @(negedge clk); drive(4'b0011, 4'b0011, 4'b0010, 0, 64'h91, 0);
    #1 check("t6_grant", 4'b0001, 0,0,0, 64'h0, 0, 0, 0);
    @(negedge clk); drive(4'b0010, 4'b0010, 4'b0010, 0, 64'h91, 0);
    #1 check("t6_b1", 4'b0001, 1,1,0, 64'h91, 0, 0, 0);
    for (int c = 3; c < 10; c++) begin
      @(negedge clk);
      #1 check($sformatf("t6_stall%0d", c), 4'b0001, 0,0,0, 64'h91, 0, 0, 0);
    end
    @(negedge clk);
    #1 check("t6_fire", 4'b0000, 0,0,0, 64'h91, 0, 0, 0);
    @(negedge clk);
    #1 check("t6_term", 4'b0000, 1,0,1, 64'h0, 0, 0, 1);
    @(negedge clk);
    #1 check("t6_next", 4'b0010, 0,0,0, 64'h0, 0, 1, 0);
    @(negedge clk); drive(4'b0000, 4'b0000, 4'b0000, 0, 64'h0, 0);
    #1 check("t6_nbeat", 4'b0000, 1,1,1, 64'h0001_0000_0000_0091, 0, 1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
